amcal_seq_mult_ctrl: RTL

//   Sequenced AMCAL approximate 8x8 multiplier built around one time-shared leading-one detector (LOD).

---
 rtl/amcal_seq_mult_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/amcal_seq_mult_ctrl.sv
// AMCAL approximate 8x8 multiplier sequenced over one time-shared LOD.
// Define AMCAL_ROUND_EN for half-up mantissa rounding (default: truncate).
module amcal_seq_mult_ctrl #(
  parameter int ZERO_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  ain,
  input  logic [7:0]  bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, LODA, LODB, MUL, DONE
  } state_t;

  state_t      state;
  logic [7:0]  a_q, b_q, lod_x;
  logic [2:0]  ka, ma, kb, mb;
  logic [2:0]  lod_k, lod_m;
  logic [5:0]  p6;
  logic [3:0]  ksum;
  logic [15:0] prod_c;
  logic        zero_in;

  assign lod_x = (state == LODA) ? a_q : b_q;

  always_comb begin
    lod_k = '0;
    for (int i = 0; i < 8; i++)
      if (lod_x[i]) lod_k = 3'(i);
  end

  // Shifting the leading one down to a fixed slot zero-fills k<2 for free.
`ifdef AMCAL_ROUND_EN
  logic [3:0] lod_w;
  assign lod_w = 4'({lod_x, 3'b000} >> lod_k);
  assign lod_m = (lod_w[0] && lod_w[3:1] != 3'b111)
               ? lod_w[3:1] + 3'd1
               : lod_w[3:1];
`else
  logic [2:0] lod_w;
  assign lod_w = 3'({lod_x, 2'b00} >> lod_k);
  assign lod_m = lod_w;
`endif

  assign p6      = {3'b000, ma} * {3'b000, mb};
  assign ksum    = {1'b0, ka} + {1'b0, kb};
  assign prod_c  = (ksum >= 4'd4)
                 ? {10'd0, p6} << (ksum - 4'd4)
                 : {10'd0, p6} >> (4'd4 - ksum);
  assign zero_in = (ain == 8'd0) || (bin == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      prod      <= '0;
      busy      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      ka        <= '0;
      ma        <= '0;
      kb        <= '0;
      mb        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= ain;
            b_q      <= bin;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (ZERO_BYPASS != 0 && zero_in) begin
              prod      <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= LODA;
            end
          end
        end
        LODA: begin
          ka    <= lod_k;
          ma    <= lod_m;
          state <= LODB;
        end
        LODB: begin
          kb    <= lod_k;
          mb    <= lod_m;
          state <= MUL;
        end
        MUL: begin
          prod      <= prod_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
